// File: rtl/dma_pkg.sv
// dma_pkg: TL-UL opcode constants, channel-index width helper and outstanding-limit default
package dma_pkg;
  localparam logic [2:0] TL_A_GET = 3'd4;
  localparam logic [2:0] TL_A_PUT_FULL = 3'd0;
  localparam logic [2:0] TL_A_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] TL_D_ACCESS_ACK = 3'd0;
  localparam logic [2:0] TL_D_ACCESS_ACK_DATA = 3'd1;
  localparam int DMA_MAX_OUTSTANDING = 4;
  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/dma_rr_arbiter.sv
// dma_rr_arbiter: one-hot grant over N requesters; round-robin with DMA_ARB_RR_EN, fixed lowest-index priority otherwise
module dma_rr_arbiter
  import dma_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);
`ifdef DMA_ARB_RR_EN
  localparam int W = chan_w(N);
  logic [W-1:0] r_ptr;
  logic [W-1:0] w_win;
  int w_j;
  // Scan from the farthest offset down so the requester nearest the pointer wins
  always_comb begin
    gnt = '0;
    w_win = r_ptr;
    w_j = 0;
    for (int i = N - 1; i >= 0; i--) begin
      w_j = (int'(r_ptr) + i) % N;
      if (req[w_j]) begin
        gnt = '0;
        gnt[w_j] = 1'b1;
        w_win = W'(w_j);
      end
    end
  end
  // Next search begins just past the most recent winner
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_ptr <= '0;
    else if (advance) r_ptr <= (int'(w_win) == N - 1) ? '0 : w_win + 1'b1;
`else
  logic w_unused;
  assign w_unused = &{1'b0, clk, rst_n, advance};
  // Lowest set request index wins
  always_comb begin
    gnt = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req[i]) begin
        gnt = '0;
        gnt[i] = 1'b1;
      end
  end
`endif
endmodule

// File: rtl/dma_master_arbiter.sv
// dma_master_arbiter: merges NoC per-channel TL-UL masters onto one port; DMA_ARB_RR_EN selects round-robin arbitration
module dma_master_arbiter
  import dma_pkg::*;
#(
  parameter int NoC = 2,
  parameter int TL_RS = 4,
  parameter int MAX_OUTSTANDING = DMA_MAX_OUTSTANDING
) (
  input  logic                dma_clock_i,
  input  logic                dma_reset_i,
  input  logic [3*NoC-1:0]    sa_opcode,
  input  logic [3*NoC-1:0]    sa_param,
  input  logic [4*NoC-1:0]    sa_size,
  input  logic [32*NoC-1:0]   sa_address,
  input  logic [32*NoC-1:0]   sa_data,
  input  logic [4*NoC-1:0]    sa_mask,
  input  logic [NoC-1:0]      sa_corrupt,
  input  logic [NoC-1:0]      sa_valid,
  output logic [NoC-1:0]      sa_ready,
  output logic [3*NoC-1:0]    sd_opcode,
  output logic [2*NoC-1:0]    sd_param,
  output logic [4*NoC-1:0]    sd_size,
  output logic [32*NoC-1:0]   sd_data,
  output logic [NoC-1:0]      sd_denied,
  output logic [NoC-1:0]      sd_corrupt,
  output logic [NoC-1:0]      sd_valid,
  input  logic [NoC-1:0]      sd_ready,
  output logic [2:0]          m_a_opcode,
  output logic [2:0]          m_a_param,
  output logic [3:0]          m_a_size,
  output logic [TL_RS-1:0]    m_a_source,
  output logic [31:0]         m_a_address,
  output logic [3:0]          m_a_mask,
  output logic [31:0]         m_a_data,
  output logic                m_a_corrupt,
  output logic                m_a_valid,
  input  logic                m_a_ready,
  input  logic [2:0]          m_d_opcode,
  input  logic [1:0]          m_d_param,
  input  logic [3:0]          m_d_size,
  input  logic [TL_RS-1:0]    m_d_source,
  input  logic                m_d_denied,
  input  logic                m_d_corrupt,
  input  logic                m_d_valid,
  input  logic [31:0]         m_d_data,
  output logic                m_d_ready,
  output logic                d_err_o
);
  localparam int CW = chan_w(NoC);
  if (TL_RS < $clog2(NoC) || MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 15) begin : g_bad_cfg
    $error("dma_master_arbiter: TL_RS too narrow for NoC or MAX_OUTSTANDING outside 1..15");
  end
  logic [NoC-1:0] w_elig, w_gnt, w_sel_d, w_inc, w_dec, w_zero;
  logic w_load, w_accept, w_hit;
  logic [CW-1:0] w_win;
  logic [2:0] w_op, w_par;
  logic [3:0] w_size, w_mask;
  logic [31:0] w_addr, w_data;
  logic w_corrupt;
  logic [3:0] r_cnt [NoC];
  logic r_d_err;
  for (genvar k = 0; k < NoC; k++) begin : g_ch
    assign w_elig[k] = sa_valid[k] & (r_cnt[k] < 4'(MAX_OUTSTANDING));
    assign w_sel_d[k] = m_d_source == TL_RS'(k);
    assign w_zero[k] = r_cnt[k] == 4'd0;
    assign sd_valid[k] = m_d_valid & w_sel_d[k];
    assign w_dec[k] = m_d_valid & m_d_ready & w_sel_d[k];
  end
  dma_rr_arbiter #(.N(NoC)) u_arb (
    .clk(dma_clock_i),
    .rst_n(dma_reset_i),
    .req(w_elig),
    .advance(w_accept),
    .gnt(w_gnt)
  );
  assign w_load = ~m_a_valid | m_a_ready;
  assign sa_ready = (dma_reset_i & w_load) ? w_gnt : '0;
  assign w_accept = |sa_ready;
  assign w_inc = sa_ready;
  assign w_hit = |w_sel_d;
  assign sd_opcode = {NoC{m_d_opcode}};
  assign sd_param = {NoC{m_d_param}};
  assign sd_size = {NoC{m_d_size}};
  assign sd_data = {NoC{m_d_data}};
  assign sd_denied = {NoC{m_d_denied}};
  assign sd_corrupt = {NoC{m_d_corrupt}};
  assign d_err_o = r_d_err;
  // Unroutable sources are sunk so the interconnect never stalls on them
  always_comb begin
    m_d_ready = 1'b1;
    for (int k = 0; k < NoC; k++)
      if (w_sel_d[k]) m_d_ready = sd_ready[k];
  end
  // Select the granted channel's beat and its index
  always_comb begin
    w_win = '0;
    w_op = '0;
    w_par = '0;
    w_size = '0;
    w_addr = '0;
    w_mask = '0;
    w_data = '0;
    w_corrupt = 1'b0;
    for (int k = 0; k < NoC; k++)
      if (w_gnt[k]) begin
        w_win = CW'(k);
        w_op = sa_opcode[k*3 +: 3];
        w_par = sa_param[k*3 +: 3];
        w_size = sa_size[k*4 +: 4];
        w_addr = sa_address[k*32 +: 32];
        w_mask = sa_mask[k*4 +: 4];
        w_data = sa_data[k*32 +: 32];
        w_corrupt = sa_corrupt[k];
      end
  end
  // One-entry A output register, reloaded whenever it is empty or draining
  always_ff @(posedge dma_clock_i or negedge dma_reset_i)
    if (!dma_reset_i) begin
      m_a_valid <= 1'b0;
      m_a_opcode <= '0;
      m_a_param <= '0;
      m_a_size <= '0;
      m_a_source <= '0;
      m_a_address <= '0;
      m_a_mask <= '0;
      m_a_data <= '0;
      m_a_corrupt <= 1'b0;
    end else if (w_load) begin
      m_a_valid <= w_accept;
      m_a_opcode <= w_op;
      m_a_param <= w_par;
      m_a_size <= w_size;
      m_a_source <= TL_RS'(w_win);
      m_a_address <= w_addr;
      m_a_mask <= w_mask;
      m_a_data <= w_data;
      m_a_corrupt <= w_corrupt;
    end
  // Per-channel in-flight counters; a simultaneous accept and response cancel out
  always_ff @(posedge dma_clock_i or negedge dma_reset_i)
    if (!dma_reset_i) for (int k = 0; k < NoC; k++) r_cnt[k] <= '0;
    else for (int k = 0; k < NoC; k++)
      if (w_inc[k] & ~w_dec[k]) r_cnt[k] <= r_cnt[k] + 4'd1;
      else if (w_dec[k] & ~w_inc[k] & ~w_zero[k]) r_cnt[k] <= r_cnt[k] - 4'd1;
  // Flag D beats that are unroutable or answer nothing in flight
  always_ff @(posedge dma_clock_i or negedge dma_reset_i)
    if (!dma_reset_i) r_d_err <= 1'b0;
    else r_d_err <= (m_d_valid & ~w_hit) | (|(w_dec & ~w_inc & w_zero));
endmodule

// File: tb/tb_dma_master_arbiter.sv
// tb_dma_master_arbiter: directed scenarios plus randomized traffic checked against a behavioural model
module tb_dma_master_arbiter;
  localparam int NOC = 2;
  localparam int RS = 4;
  localparam int MAXO = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3*NOC-1:0] sa_opcode, sa_param;
  logic [4*NOC-1:0] sa_size, sa_mask;
  logic [32*NOC-1:0] sa_address, sa_data;
  logic [NOC-1:0] sa_corrupt, sa_valid, sa_ready;
  logic [3*NOC-1:0] sd_opcode;
  logic [2*NOC-1:0] sd_param;
  logic [4*NOC-1:0] sd_size;
  logic [32*NOC-1:0] sd_data;
  logic [NOC-1:0] sd_denied, sd_corrupt, sd_valid, sd_ready;
  logic [2:0] m_a_opcode, m_a_param;
  logic [3:0] m_a_size, m_a_mask;
  logic [RS-1:0] m_a_source;
  logic [31:0] m_a_address, m_a_data;
  logic m_a_corrupt, m_a_valid, m_a_ready;
  logic [2:0] m_d_opcode;
  logic [1:0] m_d_param;
  logic [3:0] m_d_size;
  logic [RS-1:0] m_d_source;
  logic m_d_denied, m_d_corrupt, m_d_valid, m_d_ready;
  logic [31:0] m_d_data;
  logic d_err_o;
  int n_chk = 0;
  int n_fail = 0;
  dma_master_arbiter #(.NoC(NOC), .TL_RS(RS), .MAX_OUTSTANDING(MAXO)) dut (
    .dma_clock_i(clk), .dma_reset_i(rst_n),
    .sa_opcode(sa_opcode), .sa_param(sa_param), .sa_size(sa_size), .sa_address(sa_address),
    .sa_data(sa_data), .sa_mask(sa_mask), .sa_corrupt(sa_corrupt), .sa_valid(sa_valid), .sa_ready(sa_ready),
    .sd_opcode(sd_opcode), .sd_param(sd_param), .sd_size(sd_size), .sd_data(sd_data),
    .sd_denied(sd_denied), .sd_corrupt(sd_corrupt), .sd_valid(sd_valid), .sd_ready(sd_ready),
    .m_a_opcode(m_a_opcode), .m_a_param(m_a_param), .m_a_size(m_a_size), .m_a_source(m_a_source),
    .m_a_address(m_a_address), .m_a_mask(m_a_mask), .m_a_data(m_a_data), .m_a_corrupt(m_a_corrupt),
    .m_a_valid(m_a_valid), .m_a_ready(m_a_ready),
    .m_d_opcode(m_d_opcode), .m_d_param(m_d_param), .m_d_size(m_d_size), .m_d_source(m_d_source),
    .m_d_denied(m_d_denied), .m_d_corrupt(m_d_corrupt), .m_d_valid(m_d_valid), .m_d_data(m_d_data),
    .m_d_ready(m_d_ready), .d_err_o(d_err_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  // Reference model: per-channel in-flight counts, arbitration pointer, the one held beat and the error flag
  int cnt [NOC];
  int ptr;
  logic mv, mcor, merr;
  logic [2:0] mop, mpar;
  logic [3:0] msz, mmsk;
  logic [31:0] madr, mdat;
  int msrc;
  int n_cnt [NOC];
  int n_ptr;
  logic n_mv, n_mcor, n_merr;
  logic [2:0] n_mop, n_mpar;
  logic [3:0] n_msz, n_mmsk;
  logic [31:0] n_madr, n_mdat;
  int n_msrc;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int k = 0; k < NOC; k++) cnt[k] = 0;
      ptr = 0; mv = 0; merr = 0; mop = 0; mpar = 0; msz = 0; mmsk = 0; madr = 0; mdat = 0; mcor = 0; msrc = 0;
    end else begin
      cnt = n_cnt; ptr = n_ptr; mv = n_mv; merr = n_merr; mop = n_mop; mpar = n_mpar;
      msz = n_msz; mmsk = n_mmsk; madr = n_madr; mdat = n_mdat; mcor = n_mcor; msrc = n_msrc;
    end
  always @(negedge clk) begin
    int win, c, src;
    logic ld, inc, dec, exp_mdr;
    logic [NOC-1:0] exp_rdy, exp_sdv;
    win = -1;
    c = 0;
    ld = !mv || m_a_ready;
    for (int i = 0; i < NOC; i++) begin
`ifdef DMA_ARB_RR_EN
      c = (ptr + i) % NOC;
`else
      c = i;
`endif
      if (win < 0 && sa_valid[c] && cnt[c] < MAXO) win = c;
    end
    if (!rst_n || !ld) win = -1;
    exp_rdy = '0;
    if (win >= 0) exp_rdy[win] = 1'b1;
    src = int'(m_d_source);
    exp_sdv = '0;
    if (m_d_valid && src < NOC) exp_sdv[src] = 1'b1;
    exp_mdr = (src < NOC) ? sd_ready[src] : 1'b1;
    chk("sa_ready", 64'(sa_ready), 64'(exp_rdy));
    chk("m_a_valid", 64'(m_a_valid), 64'(mv));
    if (mv) begin
      chk("m_a_fields", {m_a_opcode, m_a_param, m_a_size, m_a_mask, m_a_corrupt, 4'(m_a_source)},
          {mop, mpar, msz, mmsk, mcor, 4'(msrc)});
      chk("m_a_address", 64'(m_a_address), 64'(madr));
      chk("m_a_data", 64'(m_a_data), 64'(mdat));
    end
    chk("d_err_o", 64'(d_err_o), 64'(merr));
    chk("sd_valid", 64'(sd_valid), 64'(exp_sdv));
    chk("m_d_ready", 64'(m_d_ready), 64'(exp_mdr));
    chk("sd_data", 64'(sd_data), 64'({NOC{m_d_data}}));
    chk("sd_fields", {sd_opcode, sd_param, sd_size, sd_denied, sd_corrupt},
        {{NOC{m_d_opcode}}, {NOC{m_d_param}}, {NOC{m_d_size}}, {NOC{m_d_denied}}, {NOC{m_d_corrupt}}});
    n_cnt = cnt; n_ptr = ptr; n_mv = mv; n_mop = mop; n_mpar = mpar; n_msz = msz; n_mmsk = mmsk;
    n_madr = madr; n_mdat = mdat; n_mcor = mcor; n_msrc = msrc; n_merr = 1'b0;
    if (rst_n) begin
      if (ld) n_mv = win >= 0;
      if (win >= 0) begin
        n_mop = sa_opcode[win*3 +: 3]; n_mpar = sa_param[win*3 +: 3]; n_msz = sa_size[win*4 +: 4];
        n_mmsk = sa_mask[win*4 +: 4]; n_madr = sa_address[win*32 +: 32]; n_mdat = sa_data[win*32 +: 32];
        n_mcor = sa_corrupt[win]; n_msrc = win; n_ptr = (win + 1) % NOC;
      end
      n_merr = m_d_valid && src >= NOC;
      for (int k = 0; k < NOC; k++) begin
        inc = win == k;
        dec = m_d_valid && exp_mdr && src == k;
        if (inc && !dec) n_cnt[k] = cnt[k] + 1;
        else if (dec && !inc) begin
          if (cnt[k] == 0) n_merr = 1'b1;
          else n_cnt[k] = cnt[k] - 1;
        end
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask
  task automatic set_ch(input int k, input logic [2:0] op, input logic [31:0] adr, input logic [31:0] dat);
    sa_opcode[k*3 +: 3] = op;
    sa_param[k*3 +: 3] = 3'd0;
    sa_size[k*4 +: 4] = 4'd2;
    sa_address[k*32 +: 32] = adr;
    sa_data[k*32 +: 32] = dat;
    sa_mask[k*4 +: 4] = 4'hf;
    sa_corrupt[k] = 1'b0;
  endtask
  task automatic set_d(input logic v, input logic [RS-1:0] s, input logic [2:0] op, input logic [31:0] dat);
    m_d_valid = v;
    m_d_source = s;
    m_d_opcode = op;
    m_d_data = dat;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    sa_valid = '0;
    m_d_valid = 1'b0;
    m_a_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;
  endtask
  logic [NOC-1:0] g [4];
  logic [NOC-1:0] g_exp [4];
  initial begin
    sa_opcode = '0; sa_param = '0; sa_size = '0; sa_mask = '0; sa_address = '0; sa_data = '0;
    sa_corrupt = '0; sa_valid = '1; sd_ready = '1; m_a_ready = 1'b1;
    m_d_opcode = '0; m_d_param = '0; m_d_size = '0; m_d_source = '0;
    m_d_denied = 1'b0; m_d_corrupt = 1'b0; m_d_valid = 1'b0; m_d_data = '0;
    step();
    step();
    at_neg();
    chk("rst_sa_ready", 64'(sa_ready), 64'd0);
    chk("rst_m_a_valid", 64'(m_a_valid), 64'd0);
    chk("rst_d_err", 64'(d_err_o), 64'd0);
    step();
    rst_n = 1'b1;
    sa_valid = '0;
    set_ch(0, 3'd4, 32'h1000, 32'h0);
    sa_valid = 2'b01;
    at_neg();
    chk("t1_sa_ready", 64'(sa_ready), 64'h1);
    step();
    sa_valid = '0;
    at_neg();
    chk("t1_m_a_valid", 64'(m_a_valid), 64'd1);
    chk("t1_address", 64'(m_a_address), 64'h1000);
    chk("t1_source", 64'(m_a_source), 64'd0);
    chk("t1_opcode", 64'(m_a_opcode), 64'd4);
    step();
    set_d(1'b1, 4'd0, 3'd1, 32'hDEADBEEF);
    at_neg();
    chk("t1_sd_valid", 64'(sd_valid), 64'h1);
    chk("t1_sd_data0", 64'(sd_data[31:0]), 64'hDEADBEEF);
    chk("t1_m_d_ready", 64'(m_d_ready), 64'd1);
    step();
    m_d_valid = 1'b0;
    at_neg();
    chk("t1_no_err", 64'(d_err_o), 64'd0);
    do_reset();
    set_ch(0, 3'd4, 32'h100, 32'h0);
    set_ch(1, 3'd4, 32'h200, 32'h0);
    sa_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      at_neg();
      g[i] = sa_ready;
      step();
    end
    sa_valid = '0;
`ifdef DMA_ARB_RR_EN
    g_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    g_exp = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    for (int i = 0; i < 4; i++) chk($sformatf("t2_grant%0d", i), 64'(g[i]), 64'(g_exp[i]));
    do_reset();
    m_a_ready = 1'b0;
    set_ch(0, 3'd0, 32'h2000, 32'h11);
    sa_valid = 2'b01;
    at_neg();
    chk("t3_first_accept", 64'(sa_ready), 64'h1);
    step();
    set_ch(0, 3'd0, 32'h3000, 32'h22);
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk("t3_hold_valid", 64'(m_a_valid), 64'd1);
      chk("t3_hold_addr", 64'(m_a_address), 64'h2000);
      chk("t3_hold_no_ready", 64'(sa_ready), 64'd0);
      step();
    end
    m_a_ready = 1'b1;
    at_neg();
    chk("t3_release_ready", 64'(sa_ready), 64'h1);
    chk("t3_release_addr", 64'(m_a_address), 64'h2000);
    step();
    sa_valid = '0;
    at_neg();
    chk("t3_next_addr", 64'(m_a_address), 64'h3000);
    chk("t3_next_data", 64'(m_a_data), 64'h22);
    do_reset();
    set_ch(1, 3'd0, 32'h4000, 32'h55);
    sa_valid = 2'b10;
    for (int i = 0; i < 4; i++) begin
      at_neg();
      chk("t4_put_accept", 64'(sa_ready), 64'h2);
      step();
    end
    at_neg();
    chk("t4_fifth_blocked", 64'(sa_ready), 64'd0);
    step();
    set_d(1'b1, 4'd1, 3'd0, 32'h0);
    at_neg();
    chk("t4_still_blocked", 64'(sa_ready), 64'd0);
    step();
    m_d_valid = 1'b0;
    at_neg();
    chk("t4_fifth_accepted", 64'(sa_ready), 64'h2);
    chk("t4_no_err", 64'(d_err_o), 64'd0);
    step();
    sa_valid = '0;
    set_d(1'b1, 4'd3, 3'd0, 32'h0);
    at_neg();
    chk("t5_m_d_ready", 64'(m_d_ready), 64'd1);
    chk("t5_no_sd_valid", 64'(sd_valid), 64'd0);
    step();
    m_d_valid = 1'b0;
    at_neg();
    chk("t5_err_pulse", 64'(d_err_o), 64'd1);
    step();
    at_neg();
    chk("t5_err_once", 64'(d_err_o), 64'd0);
    do_reset();
    set_ch(0, 3'd4, 32'h5000, 32'h0);
    sa_valid = 2'b01;
    step();
    step();
    sa_valid = '0;
    m_a_ready = 1'b0;
    at_neg();
    chk("t6_held", 64'(m_a_valid), 64'd1);
    step();
    rst_n = 1'b0;
    at_neg();
    chk("t6_in_reset", 64'(m_a_valid), 64'd0);
    step();
    rst_n = 1'b1;
    m_a_ready = 1'b1;
    at_neg();
    chk("t6_after_release", 64'(m_a_valid), 64'd0);
    step();
    set_d(1'b1, 4'd0, 3'd1, 32'h0);
    step();
    m_d_valid = 1'b0;
    at_neg();
    chk("t6_late_d_err", 64'(d_err_o), 64'd1);
    step();
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < NOC; k++) begin
        set_ch(k, 3'($urandom_range(0, 4)), $urandom, $urandom);
        sa_param[k*3 +: 3] = 3'($urandom);
        sa_size[k*4 +: 4] = 4'($urandom);
        sa_mask[k*4 +: 4] = 4'($urandom);
        sa_corrupt[k] = 1'($urandom);
      end
      sa_valid = NOC'($urandom);
      m_a_ready = ($urandom % 4) != 0;
      sd_ready = NOC'($urandom);
      set_d(($urandom % 3) == 0, ($urandom % 8 == 0) ? RS'($urandom_range(2, 15)) : RS'($urandom % 2),
            3'($urandom), $urandom);
      m_d_param = 2'($urandom);
      m_d_size = 4'($urandom);
      m_d_denied = 1'($urandom);
      m_d_corrupt = 1'($urandom);
      step();
    end
    sa_valid = '0;
    m_d_valid = 1'b0;
    step();
    at_neg();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
